// File: rtl/mmss_timer.sv
// -----------------------------------------------------------------------------
// mmss_timer
//   MM:SS up/down timer for the display driver. The 1 Hz square wave from the
//   divider is asynchronous to clk, so it is synchronised and edge-detected.
//   The count advances once per rising edge of tick_1hz while in RUN.
//   All digits are kept in BCD.
//
// Parameters
//   MAX_MIN      highest minute value (0..99); the up-count wraps after MAX_MIN:59
//   SYNC_STAGES  synchroniser flops on tick_1hz ahead of the edge flop (2 or 3)
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   tick_1hz    1 Hz square wave, asynchronous to clk
//   start_stop  one-cycle pulse, toggles run/pause
//   clear       one-cycle pulse, forces 00:00 and IDLE
//   dir         0 = count up, 1 = count down
//   load        one-cycle pulse, loads load_mm/load_ss
//   load_mm     BCD minutes {tens, ones}
//   load_ss     BCD seconds {tens, ones}
//   min_bcd     current minutes, BCD
//   sec_bcd     current seconds, BCD
//   running     high while in RUN
//   done        high while in DONE
//   wrap        one-cycle pulse when the up-count wraps to 00:00
//   load_err    one-cycle pulse when a load is rejected
// -----------------------------------------------------------------------------
module mmss_timer #(
    parameter int MAX_MIN     = 59,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       dir,
    input  logic       load,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic       wrap,
    output logic       load_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] MAX_T       = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_O       = 4'(MAX_MIN % 10);
    localparam logic [7:0] MAX_MIN_VAL = 8'(MAX_MIN);

    state_t state;
    state_t state_n;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   tick_p;

    // Count held as {min tens, min ones, sec tens, sec ones}
    logic [15:0] cnt_q;
    logic [15:0] cnt_n;
    logic [3:0]  min_t, min_o, sec_t, sec_o;

    logic [15:0] up_cnt;
    logic        up_wrap;
    logic [15:0] dn_cnt;
    logic        cnt_zero;
    logic        cnt_one;

    logic [7:0]  load_min_val;
    logic        load_ok;

    logic        do_load;
    logic        do_step;
    logic        load_rej;
    logic        wrap_n;

    assign min_t   = cnt_q[15:12];
    assign min_o   = cnt_q[11:8];
    assign sec_t   = cnt_q[7:4];
    assign sec_o   = cnt_q[3:0];
    assign min_bcd = cnt_q[15:8];
    assign sec_bcd = cnt_q[7:0];

    // Synchroniser chain plus edge flop; tick_p is a one-clk pulse per
    // rising edge of tick_1hz as seen after synchronisation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_1hz};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick_p = sync_q[SYNC_STAGES-1] & ~edge_q;

    // BCD increment with ripple carry; wraps from MAX_MIN:59 to 00:00.
    always_comb begin
        up_cnt  = {min_t, min_o, sec_t, sec_o + 4'd1};
        up_wrap = 1'b0;
        if (sec_o == 4'd9) begin
            if (sec_t != 4'd5) begin
                up_cnt = {min_t, min_o, sec_t + 4'd1, 4'd0};
            end else if ((min_t == MAX_T) && (min_o == MAX_O)) begin
                up_cnt  = 16'h0000;
                up_wrap = 1'b1;
            end else if (min_o != 4'd9) begin
                up_cnt = {min_t, min_o + 4'd1, 8'h00};
            end else begin
                up_cnt = {min_t + 4'd1, 4'd0, 8'h00};
            end
        end
    end

    // BCD decrement with ripple borrow; 00:00 is never decremented.
    always_comb begin
        dn_cnt = {min_t, min_o, sec_t, sec_o - 4'd1};
        if (sec_o == 4'd0) begin
            if (sec_t != 4'd0) begin
                dn_cnt = {min_t, min_o, sec_t - 4'd1, 4'd9};
            end else if (min_o != 4'd0) begin
                dn_cnt = {min_t, min_o - 4'd1, 4'd5, 4'd9};
            end else if (min_t != 4'd0) begin
                dn_cnt = {min_t - 4'd1, 4'd9, 4'd5, 4'd9};
            end else begin
                dn_cnt = 16'h0000;
            end
        end
    end

    assign cnt_zero = (cnt_q == 16'h0000);
    assign cnt_one  = (cnt_q == 16'h0001);

    // A load is valid only with proper BCD digits, seconds tens of at most
    // 5, and a minute value that fits under MAX_MIN.
    assign load_min_val = ({4'd0, load_mm[7:4]} * 8'd10) + {4'd0, load_mm[3:0]};
    assign load_ok = (load_mm[7:4] <= 4'd9) && (load_mm[3:0] <= 4'd9) &&
                     (load_ss[7:4] <= 4'd5) && (load_ss[3:0] <= 4'd9) &&
                     (load_min_val <= MAX_MIN_VAL);

    // State register; running and done are registered from the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt_q    <= 16'h0000;
            running  <= 1'b0;
            done     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_n;
            cnt_q    <= cnt_n;
            running  <= (state_n == RUN);
            done     <= (state_n == DONE);
            wrap     <= wrap_n;
            load_err <= load_rej;
        end
    end

    // Next-state logic. Priority is clear > load > start_stop > tick_p.
    // A load in RUN is ignored entirely, so the lower-priority inputs still
    // act in that cycle. start_stop in RUN still lets a coincident tick land.
    always_comb begin
        state_n  = state;
        do_load  = 1'b0;
        do_step  = 1'b0;
        load_rej = 1'b0;
        if (clear) begin
            state_n = IDLE;
        end else if (load && (state != RUN)) begin
            if (load_ok) begin
                do_load = 1'b1;
                state_n = IDLE;
            end else begin
                load_rej = 1'b1;
            end
        end else if (start_stop) begin
            case (state)
                IDLE, PAUSE: begin
                    if (!(dir && cnt_zero)) begin
                        state_n = RUN;
                    end
                end
                RUN: begin
                    do_step = tick_p;
                    if (tick_p && dir && cnt_one) begin
                        state_n = DONE;
                    end else begin
                        state_n = PAUSE;
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end else if (tick_p && (state == RUN)) begin
            do_step = 1'b1;
            if (dir && cnt_one) begin
                state_n = DONE;
            end
        end
    end

    // Count and pulse outputs for the next cycle.
    always_comb begin
        cnt_n  = cnt_q;
        wrap_n = 1'b0;
        if (clear) begin
            cnt_n = 16'h0000;
        end else if (do_load) begin
            cnt_n = {load_mm, load_ss};
        end else if (do_step) begin
            if (!dir) begin
                cnt_n  = up_cnt;
                wrap_n = up_wrap;
            end else begin
                cnt_n = dn_cnt;
            end
        end
    end

endmodule

// File: tb/tb_mmss_timer.sv
// -----------------------------------------------------------------------------
// tb_mmss_timer
//   Self-checking bench for mmss_timer. A reference model tracks the count as
//   a plain number of seconds plus a state code, and every output is compared
//   against it on falling clock edges.
// -----------------------------------------------------------------------------
module tb_mmss_timer;

    localparam int MAX_MIN = 59;
    localparam int PERIOD  = (MAX_MIN + 1) * 60;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic       start_stop;
    logic       clear;
    logic       dir;
    logic       load;
    logic [7:0] load_mm;
    logic [7:0] load_ss;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       done;
    logic       wrap;
    logic       load_err;

    int compared   = 0;
    int mismatched = 0;

    int m_state;
    int m_total;
    bit exp_wrap;
    bit exp_err;

    mmss_timer #(
        .MAX_MIN    (MAX_MIN),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_1hz  (tick_1hz),
        .start_stop(start_stop),
        .clear     (clear),
        .dir       (dir),
        .load      (load),
        .load_mm   (load_mm),
        .load_ss   (load_ss),
        .min_bcd   (min_bcd),
        .sec_bcd   (sec_bcd),
        .running   (running),
        .done      (done),
        .wrap      (wrap),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return (int'(b[7:4]) * 10) + int'(b[3:0]);
    endfunction

    function automatic bit load_valid(input logic [7:0] mm, input logic [7:0] ss);
        return (mm[7:4] <= 4'd9) && (mm[3:0] <= 4'd9) &&
               (ss[7:4] <= 4'd5) && (ss[3:0] <= 4'd9) &&
               (from_bcd(mm) <= MAX_MIN);
    endfunction

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".min"},  min_bcd, to_bcd(m_total / 60));
        checkVal({tag, ".sec"},  sec_bcd, to_bcd(m_total % 60));
        checkVal({tag, ".run"},  {7'd0, running},  {7'd0, (m_state == S_RUN)});
        checkVal({tag, ".done"}, {7'd0, done},     {7'd0, (m_state == S_DONE)});
        checkVal({tag, ".wrap"}, {7'd0, wrap},     {7'd0, exp_wrap});
        checkVal({tag, ".lerr"}, {7'd0, load_err}, {7'd0, exp_err});
    endtask

    // One second of time passing in RUN, in terms of total seconds.
    task automatic modelAdvance();
        if (!dir) begin
            m_total = m_total + 1;
            if (m_total == PERIOD) begin
                m_total  = 0;
                exp_wrap = 1'b1;
            end
        end else if (m_total > 0) begin
            m_total = m_total - 1;
            if (m_total == 0) begin
                m_state = S_DONE;
            end
        end
    endtask

    task automatic modelStep(input bit clr, input bit ld, input logic [7:0] mm,
                             input logic [7:0] ss, input bit ssp, input bit tk);
        exp_wrap = 1'b0;
        exp_err  = 1'b0;
        if (clr) begin
            m_state = S_IDLE;
            m_total = 0;
        end else if (ld && (m_state != S_RUN)) begin
            if (load_valid(mm, ss)) begin
                m_total = (from_bcd(mm) * 60) + from_bcd(ss);
                m_state = S_IDLE;
            end else begin
                exp_err = 1'b1;
            end
        end else if (ssp) begin
            if ((m_state == S_IDLE) || (m_state == S_PAUSE)) begin
                if (!(dir && (m_total == 0))) begin
                    m_state = S_RUN;
                end
            end else if (m_state == S_RUN) begin
                if (tk) begin
                    modelAdvance();
                end
                if (m_state != S_DONE) begin
                    m_state = S_PAUSE;
                end
            end
        end else if (tk && (m_state == S_RUN)) begin
            modelAdvance();
        end
    endtask

    task automatic idleCycle(input string tag);
        @(negedge clk);
        exp_wrap = 1'b0;
        exp_err  = 1'b0;
        checkOutput(tag);
    endtask

    // One-cycle control pulse, checked after the edge that consumes it and
    // again one cycle later so the pulse outputs are seen to drop.
    task automatic applyStimulus(input bit clr, input bit ld, input logic [7:0] mm,
                                 input logic [7:0] ss, input bit ssp, input string tag);
        @(negedge clk);
        clear      = clr;
        load       = ld;
        load_mm    = mm;
        load_ss    = ss;
        start_stop = ssp;
        @(negedge clk);
        clear      = 1'b0;
        load       = 1'b0;
        start_stop = 1'b0;
        modelStep(clr, ld, mm, ss, ssp, 1'b0);
        checkOutput(tag);
        idleCycle({tag, ".after"});
    endtask

    // One rising edge of tick_1hz. The count must hold after sampling edges 0
    // and 1 and update after edge 2. with_ss pulses start_stop in the tick_p
    // cycle.
    task automatic doTick(input bit with_ss, input string tag);
        int gap;
        @(negedge clk);
        tick_1hz = 1'b1;
        exp_wrap = 1'b0;
        exp_err  = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".e0"});
        @(negedge clk);
        checkOutput({tag, ".e1"});
        start_stop = with_ss;
        @(negedge clk);
        start_stop = 1'b0;
        tick_1hz   = 1'b0;
        modelStep(1'b0, 1'b0, 8'h00, 8'h00, with_ss, 1'b1);
        checkOutput({tag, ".e2"});
        gap = int'($urandom_range(3, 6));
        for (int i = 0; i < gap; i++) begin
            idleCycle({tag, ".gap"});
        end
    endtask

    task automatic pauseIfRunning();
        if (m_state == S_RUN) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "pause");
        end
    endtask

    initial begin
        logic [7:0] r_mm;
        logic [7:0] r_ss;
        int         n_ticks;

        reset      = 1'b1;
        tick_1hz   = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        dir        = 1'b0;
        load       = 1'b0;
        load_mm    = 8'h00;
        load_ss    = 8'h00;
        m_state    = S_IDLE;
        m_total    = 0;
        exp_wrap   = 1'b0;
        exp_err    = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset");
        reset = 1'b0;
        idleCycle("post_reset");

        // 65 seconds counting up from 00:00
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "start_up");
        for (int i = 0; i < 65; i++) begin
            doTick(1'b0, "up65");
        end
        checkVal("up65.min_const", min_bcd, 8'h01);
        checkVal("up65.sec_const", sec_bcd, 8'h05);
        checkVal("up65.run_const", {7'd0, running}, 8'h01);

        // Wrap from MAX_MIN:59
        pauseIfRunning();
        applyStimulus(1'b0, 1'b1, 8'h59, 8'h58, 1'b0, "load_5958");
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "start_wrap");
        doTick(1'b0, "wrap_t1");
        checkVal("wrap_t1.sec_const", sec_bcd, 8'h59);
        doTick(1'b0, "wrap_t2");
        checkVal("wrap_t2.min_const", min_bcd, 8'h00);
        doTick(1'b0, "wrap_t3");
        checkVal("wrap_t3.sec_const", sec_bcd, 8'h01);

        // Countdown to DONE
        pauseIfRunning();
        dir = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h02, 1'b0, "load_0002");
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "start_down");
        doTick(1'b0, "down_t1");
        doTick(1'b0, "down_t2");
        checkVal("down_t2.done_const", {7'd0, done}, 8'h01);
        checkVal("down_t2.run_const",  {7'd0, running}, 8'h00);
        doTick(1'b0, "down_t3");
        checkVal("down_t3.sec_const", sec_bcd, 8'h00);

        // start_stop ignored in DONE
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "ss_in_done");

        // Rejected loads
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h61, 1'b0, "load_ss61");
        applyStimulus(1'b0, 1'b1, 8'h99, 8'h00, 1'b0, "load_mm99");
        applyStimulus(1'b0, 1'b1, 8'h60, 8'h00, 1'b0, "load_mm60");

        // clear, then down-count start at 00:00 is ignored
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "clear");
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "ss_down_zero");

        // start_stop coinciding with tick_p
        dir = 1'b0;
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h10, 1'b0, "load_0010");
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "start_0010");
        doTick(1'b1, "ss_tick_run");
        checkVal("ss_tick_run.sec_const", sec_bcd, 8'h11);
        doTick(1'b1, "ss_tick_pause");
        checkVal("ss_tick_pause.sec_const", sec_bcd, 8'h11);
        checkVal("ss_tick_pause.run_const", {7'd0, running}, 8'h01);
        doTick(1'b0, "after_resume");

        // load while running is ignored without load_err
        applyStimulus(1'b0, 1'b1, 8'h05, 8'h05, 1'b0, "load_in_run");

        // Asynchronous reset mid-run
        pauseIfRunning();
        applyStimulus(1'b0, 1'b1, 8'h12, 8'h34, 1'b0, "load_1234");
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "start_1234");
        doTick(1'b0, "run_1234");
        @(negedge clk);
        reset = 1'b1;
        #1;
        m_state  = S_IDLE;
        m_total  = 0;
        exp_wrap = 1'b0;
        exp_err  = 1'b0;
        checkOutput("async_reset");
        @(negedge clk);
        reset = 1'b0;
        doTick(1'b0, "post_rst_t1");
        doTick(1'b0, "post_rst_t2");

        // Randomised loads, directions and tick runs
        for (int k = 0; k < 8; k++) begin
            pauseIfRunning();
            r_mm = 8'($urandom_range(0, 255));
            r_ss = 8'($urandom_range(0, 255));
            applyStimulus(1'b0, 1'b1, r_mm, r_ss, 1'b0, "rand_raw_load");
            r_mm = to_bcd(int'($urandom_range(0, MAX_MIN)));
            r_ss = to_bcd(int'($urandom_range(0, 59)));
            if ($urandom_range(0, 1) == 1) begin
                r_mm = 8'h00;
                r_ss = to_bcd(int'($urandom_range(0, 3)));
            end
            dir = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, 1'b1, r_mm, r_ss, 1'b0, "rand_load");
            applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "rand_start");
            n_ticks = int'($urandom_range(1, 6));
            for (int t = 0; t < n_ticks; t++) begin
                doTick(1'($urandom_range(0, 4) == 0), "rand_tick");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mmss_timer.md
Name: mmss_timer

Overview:
- Seconds/minutes up/down timer that consumes the 1 Hz square wave from the 1 Hz divider and keeps an MM:SS count in BCD for the display driver.
- Runs on the fast system clock.
- Treats the 1 Hz input as asynchronous: it synchronises the input, edge-detects it and advances the count once per rising edge.
- Provides start/stop, clear, load and countdown-complete signalling.

Parameters:
- MAX_MIN, 59, highest minute value (0..99). The up-count wraps after MAX_MIN:59.
- SYNC_STAGES, 2, synchroniser flops on tick_1hz before the edge-detect flop (2 or 3).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick_1hz  in  1  1 Hz square wave from the divider, asynchronous to clk
- start_stop  in  1  one-cycle pulse, toggles run/pause
- clear  in  1  one-cycle pulse, forces 00:00 and IDLE
- dir  in  1  0 = count up, 1 = count down
- load  in  1  one-cycle pulse, loads load_mm/load_ss
- load_mm  in  8  BCD minutes {tens, ones}
- load_ss  in  8  BCD seconds {tens, ones}
- min_bcd  out  8  current minutes, BCD
- sec_bcd  out  8  current seconds, BCD
- running  out  1  high while in RUN
- done  out  1  level, high in DONE
- wrap  out  1  one-cycle pulse on up-count wrap to 00:00
- load_err  out  1  one-cycle pulse on a rejected load

Behaviour:
- Reset (async, active-high): all outputs are 0, min_bcd = sec_bcd = 8'h00, state = IDLE, and every synchroniser/edge flop is 0.
- Tick detect: tick_1hz passes through SYNC_STAGES flops plus one edge flop. tick_p = last sync AND NOT edge flop.
  - Let the first clk edge that samples tick_1hz high be edge 0.
  - With SYNC_STAGES = 2, tick_p is high between edges 1 and 2.
  - The count updates at edge 2, so latency is 3 clk edges including the sampling edge.
  - Exactly one tick_p per rising edge of tick_1hz.
  - A high tick_1hz at reset release yields one tick_p, which is ignored because the state is IDLE.
- FSM states: IDLE, RUN, PAUSE, DONE. Counting happens only in RUN.
  - IDLE: start_stop goes to RUN, except when dir = 1 and the count is 00:00, where start_stop is ignored.
  - RUN: start_stop goes to PAUSE. A down-count reaching 00:00 goes to DONE.
  - PAUSE: start_stop goes to RUN, with the same 00:00 down-count exception as IDLE.
  - DONE: start_stop is ignored; only clear or load leaves DONE.
  - clear in any state goes to IDLE, count 00:00, done = 0.
- Input priority in the same cycle: clear > load > start_stop > tick_p.
- Tick in RUN, up (dir = 0):
  - sec ones +1; 9 rolls to 0 and carries to sec tens.
  - sec tens 5 rolls to 0 and carries to minutes.
  - minute ones/tens carry the same way up to 9.
  - MAX_MIN:59 goes to 00:00 with wrap = 1 for that cycle; the state stays RUN.
- Tick in RUN, down (dir = 1):
  - Mirror borrow: sec ones 0 goes to 9, sec tens 0 goes to 5, 00:00 is never decremented.
  - 00:01 goes to 00:00 and, on the same edge, state goes to DONE and done = 1.
  - The count holds at 00:00 in DONE.
- Simultaneous start_stop and tick_p:
  - In RUN, the tick is applied and the state goes to PAUSE on the same edge.
  - In IDLE or PAUSE, the state goes to RUN and that tick is discarded.
- Changing dir mid-run takes effect on the next tick_p. No count change occurs on the dir edge itself.
- load: accepted only in IDLE, PAUSE or DONE.
  - Valid load: every digit ≤ 9, sec tens ≤ 5, minute value ≤ MAX_MIN. Count = load values, state goes to IDLE, done = 0.
  - Invalid load: count and state unchanged, load_err = 1 for one cycle.
  - load in RUN is ignored, with no load_err.
- running = (state == RUN), registered together with the state.
- done is registered and set/cleared together with the state.
- Reset asserted mid-count immediately zeroes the count and forces IDLE; counting does not resume after release.

Test Plan:
- Reset, then start_stop and 65 tick_1hz rising edges with dir = 0 → min_bcd = 8'h01, sec_bcd = 8'h05, running = 1. Each update lands exactly 3 clk edges after tick_1hz is first sampled high.
- load 59:58, start_stop, 3 ticks, up → 59:59, then 00:00 with wrap high for exactly 1 cycle, then 00:01.
- load 00:02, dir = 1, start_stop, 3 ticks → 00:01, 00:00 with done = 1 and running = 0 on the same edge. The third tick leaves 00:00.
- load 8'h61 into seconds → load_err pulse, count unchanged. load 8'h99 into minutes with MAX_MIN = 59 → rejected.
- In RUN at 00:10, pulse start_stop in the tick_p cycle → 00:11 and PAUSE. Pulse start_stop again in a tick_p cycle → RUN, count stays 00:11.
- Assert reset mid-run at 12:34 → outputs 0 and IDLE immediately, asynchronously. After release, ticks leave the count at 00:00.
